// File: rtl/pwm_tone_gen_pkg.sv
// Shared definitions for the button-controlled tone generator: board clock,
// default note ladder, the note-step decode type and the ladder legality check.
package pwm_tone_gen_pkg;

  localparam int CLK_FREQ_HZ       = 50_000_000;
  localparam int DEFAULT_BASE_HALF = 56818;
  localparam int DEFAULT_STEP_HALF = 4000;

  typedef enum logic [1:0] {
    NOTE_HOLD = 2'd0,
    NOTE_UP   = 2'd1,
    NOTE_DOWN = 2'd2
  } note_step_e;

  // The top tone must keep a half-period of at least one cycle, and note 1
  // must fit in the divider counter.
  function automatic bit ladder_legal(input int notes, input int base_half,
                                      input int step_half, input int div_w);
    longint top_half;
    longint cnt_span;
    top_half = longint'(base_half) - longint'(notes - 2) * longint'(step_half);
    cnt_span = longint'(1) << div_w;
    return (notes >= 2) && (top_half >= 1) && (longint'(base_half) < cnt_span);
  endfunction

endpackage

// File: rtl/pwm_tone_gen_button_cond.sv
// Conditions one raw board button: 2-flop synchroniser, optional debouncer
// (PWM_TONE_DEBOUNCE_EN) and a rising-edge detector giving a 1-cycle pulse.
module button_cond #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  logic       sync_ff1;
  logic       sync_ff2;
  logic       level;
  logic       level_prev;
  logic       armed;
  logic [1:0] sync_vld;

  if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
    $error("button_cond: DEBOUNCE_CYC must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= raw;
      sync_ff2 <= sync_ff1;
    end
  end

`ifdef PWM_TONE_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] db_cnt;
  logic            db_level;

  // Counts consecutive cycles the synced level disagrees with the filtered
  // level; both press and release must persist DEBOUNCE_CYC cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      db_level <= 1'b0;
    end else if (sync_ff2 == db_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt   <= '0;
      db_level <= sync_ff2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign level = db_level;
`else
  assign level = sync_ff2;
`endif

  // The detector only arms once the synchroniser has flushed after reset and
  // the button is seen released, so a press held through reset is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_vld   <= 2'b00;
      level_prev <= 1'b0;
      armed      <= 1'b0;
    end else begin
      sync_vld   <= {sync_vld[0], 1'b1};
      level_prev <= level;
      if (sync_vld[1] && !sync_ff2 && !level) begin
        armed <= 1'b1;
      end
    end
  end

  assign pulse = armed & level & ~level_prev;

endmodule

// File: rtl/pwm_tone_gen.sv
// Multi-note square-wave buzzer driver: buttons step a note index, a half-period
// divider toggles pwm. Build with PWM_TONE_DEBOUNCE_EN to debounce the buttons.
module pwm_tone_gen
  import pwm_tone_gen_pkg::*;
#(
  parameter  int NOTES        = 8,
  parameter  int DIV_W        = 20,
  parameter  int BASE_HALF    = DEFAULT_BASE_HALF,
  parameter  int STEP_HALF    = DEFAULT_STEP_HALF,
  parameter  int DEBOUNCE_CYC = 500000,
  localparam int IDX_W        = $clog2(NOTES)
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             button_add,
  input  logic             button_sub,
  output logic             pwm,
  output logic [IDX_W-1:0] note_idx,
  output logic             tone_active
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NOTES - 1);

  if (!ladder_legal(NOTES, BASE_HALF, STEP_HALF, DIV_W)) begin : g_bad_cfg
    $error("pwm_tone_gen: illegal note ladder configuration");
  end

  logic             add_p;
  logic             sub_p;
  note_step_e       step;
  logic [IDX_W-1:0] note_next;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] half_m1;
  logic [DIV_W-1:0] cnt;

  button_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_add (
    .clk   (clk_50),
    .rst_n (rst_n),
    .raw   (button_add),
    .pulse (add_p)
  );

  button_cond #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cond_sub (
    .clk   (clk_50),
    .rst_n (rst_n),
    .raw   (button_sub),
    .pulse (sub_p)
  );

  // Simultaneous presses cancel; saturated presses decode to HOLD so they
  // never restart the divider.
  always_comb begin
    step = NOTE_HOLD;
    if (add_p && !sub_p && (note_idx != IDX_MAX)) begin
      step = NOTE_UP;
    end else if (sub_p && !add_p && (note_idx != '0)) begin
      step = NOTE_DOWN;
    end
  end

  always_comb begin
    note_next = note_idx;
    case (step)
      NOTE_UP:   note_next = note_idx + 1'b1;
      NOTE_DOWN: note_next = note_idx - 1'b1;
      default:   note_next = note_idx;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      note_idx    <= '0;
      tone_active <= 1'b0;
    end else begin
      note_idx    <= note_next;
      tone_active <= (note_next != '0);
    end
  end

  // Half-period of the current note; the value for index 0 is never used.
  always_comb begin
    half    = DIV_W'(BASE_HALF) - DIV_W'(STEP_HALF) * (DIV_W'(note_idx) - DIV_W'(1));
    half_m1 = half - DIV_W'(1);
  end

  // A real note change restarts the tone with a full low half-period.
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else if ((step != NOTE_HOLD) || (note_idx == '0)) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else if (cnt == half_m1) begin
      cnt <= '0;
      pwm <= ~pwm;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_tone_gen.sv
// Self-checking bench for pwm_tone_gen: note stepping, saturation, cancelling
// presses, pwm waveform against a phase model, debounce and mid-tone reset.
module tb_pwm_tone_gen;

  localparam int NOTES        = 4;
  localparam int DIV_W        = 8;
  localparam int BASE_HALF    = 10;
  localparam int STEP_HALF    = 2;
  localparam int DEBOUNCE_CYC = 4;
  localparam int IDX_W        = $clog2(NOTES);

`ifdef PWM_TONE_DEBOUNCE_EN
  localparam int LAT  = 3 + DEBOUNCE_CYC;
  localparam int HOLD = DEBOUNCE_CYC + 2;
  localparam int GAP  = DEBOUNCE_CYC + 6;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
  localparam int GAP  = 3;
`endif
  localparam int WIN = GAP + 12;

  logic             clk_50;
  logic             rst_n;
  logic             button_add;
  logic             button_sub;
  logic             pwm;
  logic [IDX_W-1:0] note_idx;
  logic             tone_active;

  pwm_tone_gen #(
    .NOTES        (NOTES),
    .DIV_W        (DIV_W),
    .BASE_HALF    (BASE_HALF),
    .STEP_HALF    (STEP_HALF),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) dut (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .button_add  (button_add),
    .button_sub  (button_sub),
    .pwm         (pwm),
    .note_idx    (note_idx),
    .tone_active (tone_active)
  );

  // clock / reset
  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // scoreboard
  logic [31:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int model_note  = 0;
  int ref_cyc0    = 0;
  int ref_half    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got %0d expected <empty queue>", tag, got);
    end else begin
      exp = exp_q.pop_front();
      check(tag, got, exp);
    end
  endtask

  function automatic int half_of(input int k);
    return BASE_HALF - (k - 1) * STEP_HALF;
  endfunction

  // pwm waveform model: low for half cycles from the restart sample, then alternating
  function automatic logic [31:0] exp_pwm();
    if (ref_half == 0) return 32'd0;
    return 32'(((cyc - ref_cyc0) / ref_half) % 2);
  endfunction

  // driver tasks
  task automatic press_and_check(input bit add, input bit sub, input int len,
                                 input bit filtered, input string tag);
    int old_n;
    int new_n;
    old_n = model_note;
    new_n = old_n;
    if (!filtered) begin
      if (add && !sub && old_n < NOTES - 1) new_n = old_n + 1;
      else if (sub && !add && old_n > 0) new_n = old_n - 1;
    end
    exp_q.push_back(32'(old_n));
    exp_q.push_back(32'(new_n));
    exp_q.push_back(32'(new_n != 0));
    button_add = add;
    button_sub = sub;
    fork
      begin
        repeat (len) @(negedge clk_50);
        button_add = 1'b0;
        button_sub = 1'b0;
      end
    join_none
    repeat (LAT - 1) @(negedge clk_50);
    pop_check({tag, "_pre"}, 32'(note_idx));
    @(negedge clk_50);
    pop_check({tag, "_note"}, 32'(note_idx));
    pop_check({tag, "_act"}, 32'(tone_active));
    if (new_n != old_n) begin
      model_note = new_n;
      ref_cyc0   = cyc;
      ref_half   = (new_n == 0) ? 0 : half_of(new_n);
    end
  endtask

  task automatic check_pwm_window(input int n, input string tag);
    repeat (n) begin
      @(negedge clk_50);
      exp_q.push_back(exp_pwm());
      pop_check(tag, 32'(pwm));
    end
  endtask

  task automatic run_len(input logic level, output int n);
    n = 0;
    while (pwm == level && n < 100) begin
      n++;
      @(negedge clk_50);
    end
  endtask

  initial begin
    int n;
    int guard;
    rst_n      = 1'b0;
    button_add = 1'b0;
    button_sub = 1'b0;

    // 1: reset state and silence
    repeat (3) @(negedge clk_50);
    exp_q.push_back(0); pop_check("rst_pwm", 32'(pwm));
    exp_q.push_back(0); pop_check("rst_note", 32'(note_idx));
    exp_q.push_back(0); pop_check("rst_act", 32'(tone_active));
    rst_n = 1'b1;
    check_pwm_window(100, "idle_pwm");

    // 2: single press, 20-cycle period for note 1
    press_and_check(1'b1, 1'b0, 5, 1'b0, "add1");
    exp_q.push_back(32'(half_of(1))); run_len(1'b0, n); pop_check("n1_low0", 32'(n));
    exp_q.push_back(32'(half_of(1))); run_len(1'b1, n); pop_check("n1_high", 32'(n));
    exp_q.push_back(32'(half_of(1))); run_len(1'b0, n); pop_check("n1_low1", 32'(n));
    check_pwm_window(WIN, "n1_wave");

    // 3: saturation at the top, then at zero
    for (int i = 0; i < 5; i++) begin
      press_and_check(1'b1, 1'b0, HOLD, 1'b0, "sat_add");
      check_pwm_window(WIN, "sat_add_wave");
    end
    exp_q.push_back(32'(NOTES - 1)); pop_check("sat_top", 32'(note_idx));
    for (int i = 0; i < 5; i++) begin
      press_and_check(1'b0, 1'b1, HOLD, 1'b0, "sat_sub");
      check_pwm_window(WIN, "sat_sub_wave");
    end
    check_pwm_window(30, "zero_pwm");

    // 4: simultaneous presses cancel at note 2
    press_and_check(1'b1, 1'b0, HOLD, 1'b0, "up_a");
    check_pwm_window(WIN, "up_a_wave");
    press_and_check(1'b1, 1'b0, HOLD, 1'b0, "up_b");
    check_pwm_window(WIN + 3, "up_b_wave");
    press_and_check(1'b1, 1'b1, HOLD, 1'b0, "both");
    check_pwm_window(24, "both_wave");

    // 5: short glitch; filtered only with the debouncer
`ifdef PWM_TONE_DEBOUNCE_EN
    press_and_check(1'b1, 1'b0, DEBOUNCE_CYC - 1, 1'b1, "glitch");
    check_pwm_window(WIN, "glitch_wave");
    press_and_check(1'b1, 1'b0, DEBOUNCE_CYC, 1'b0, "db_press");
    check_pwm_window(WIN, "db_wave");
`else
    press_and_check(1'b1, 1'b0, 3, 1'b0, "glitch");
    check_pwm_window(WIN, "glitch_wave");
`endif
    press_and_check(1'b0, 1'b1, HOLD, 1'b0, "back2");
    check_pwm_window(WIN, "back2_wave");

    // 6: reset mid-tone with add held through reset
    guard = 0;
    while (exp_pwm() != 1 && guard < 40) begin
      @(negedge clk_50);
      guard++;
    end
    exp_q.push_back(1); pop_check("pre_rst_pwm", 32'(pwm));
    exp_q.push_back(2); pop_check("pre_rst_note", 32'(note_idx));
    rst_n      = 1'b0;
    button_add = 1'b1;
    @(negedge clk_50);
    model_note = 0;
    ref_half   = 0;
    exp_q.push_back(0); pop_check("mid_rst_pwm", 32'(pwm));
    exp_q.push_back(0); pop_check("mid_rst_note", 32'(note_idx));
    exp_q.push_back(0); pop_check("mid_rst_act", 32'(tone_active));
    rst_n = 1'b1;
    check_pwm_window(20, "held_pwm");
    exp_q.push_back(0); pop_check("held_note", 32'(note_idx));
    button_add = 1'b0;
    repeat (GAP + 2) @(negedge clk_50);
    exp_q.push_back(0); pop_check("released_note", 32'(note_idx));
    press_and_check(1'b1, 1'b0, HOLD, 1'b0, "rearm");
    check_pwm_window(WIN, "rearm_wave");

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
